// File: rtl/rv32i_pkg.sv
// Shared RV32I writeback definitions: widths, the writeback request payload and source select.
package rv32i_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREG   = 2 ** REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

    // x0 is hard-wired zero, so any write aimed at it is suppressed
    function automatic logic is_x0(input logic [REG_AW-1:0] rd);
        return rd == REG_AW'(0);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between execute/LSU/issue stages and the writeback arbiter.
interface regfile_wb_arbiter_if;
    import rv32i_pkg::*;

    logic              iss_valid;
    logic [REG_AW-1:0] iss_rd;

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [REG_AW-1:0] lsu_rd;
    logic [XLEN-1:0]   lsu_data;

    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_busy;
    logic              rs2_busy;

    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_d;

    // Pipeline side: offers results, issues loads, reads busy and the write port
    modport master (
        output iss_valid, iss_rd,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output rs1, rs2,
        input  alu_ready, lsu_ready, rs1_busy, rs2_busy,
        input  wb_we, wb_rd, wb_d
    );

    modport slave (
        input  iss_valid, iss_rd,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  rs1, rs2,
        output alu_ready, lsu_ready, rs1_busy, rs2_busy,
        output wb_we, wb_rd, wb_d
    );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Synchronous FIFO holding pending LSU load results; head is presented without a pop.
module regfile_wb_arbiter_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_req_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == CW'(0));
    assign head  = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= AW'(0);
            rd_ptr <= AW'(0);
            count  <= CW'(0);
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and LSU results onto the single regfile write port and tracks pending loads.
module regfile_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned LSU_DEPTH  = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    wb_req_t          fifo_head;
    wb_req_t          push_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             force_lsu;
    wb_src_e          src;

    logic [SW-1:0]    starve_cnt;
    logic [SW-1:0]    starve_nxt;
    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;

    logic             wb_we_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [XLEN-1:0]  wb_d_q;

    assign push_data = '{rd: bus.lsu_rd, data: bus.lsu_data};
    assign push      = bus.lsu_valid && !fifo_full;

    regfile_wb_arbiter_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // One winner per cycle; a starved LSU head preempts the ALU
    always_comb begin
        src       = WB_NONE;
        force_lsu = (starve_cnt == SW'(STARVE_MAX)) && !fifo_empty;
        if (force_lsu)          src = WB_LSU;
        else if (bus.alu_valid) src = WB_ALU;
        else if (!fifo_empty)   src = WB_LSU;
        pop = (src == WB_LSU);
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || fifo_empty)   starve_nxt = SW'(0);
        else if (src == WB_ALU)  starve_nxt = starve_cnt + SW'(1);
    end

    // Issue-side set is applied after the pop-side clear so a same-index collision stays busy
    always_comb begin
        busy_nxt = busy;
        if (pop && !is_x0(fifo_head.rd)) busy_nxt[fifo_head.rd] = 1'b0;
        if (bus.iss_valid && !is_x0(bus.iss_rd)) busy_nxt[bus.iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= SW'(0);
            busy       <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            busy       <= busy_nxt;
        end
    end

    // Write-port registers: index/data follow the winner even for x0, enable does not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_q <= 1'b0;
            wb_rd_q <= REG_AW'(0);
            wb_d_q  <= XLEN'(0);
        end else begin
            unique case (src)
                WB_ALU: begin
                    wb_we_q <= !is_x0(bus.alu_rd);
                    wb_rd_q <= bus.alu_rd;
                    wb_d_q  <= bus.alu_data;
                end
                WB_LSU: begin
                    wb_we_q <= !is_x0(fifo_head.rd);
                    wb_rd_q <= fifo_head.rd;
                    wb_d_q  <= fifo_head.data;
                end
                default: wb_we_q <= 1'b0;
            endcase
        end
    end

    assign bus.alu_ready = !force_lsu;
    assign bus.lsu_ready = !fifo_full;
    assign bus.rs1_busy  = busy[bus.rs1];
    assign bus.rs2_busy  = busy[bus.rs2];
    assign bus.wb_we     = wb_we_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_d      = wb_d_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: ALU path, scoreboard, starvation, x0, collision, reset.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.LSU_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
        bus.rs1 = '0; bus.rs2 = '0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
        chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        chk("rst_wb_d", bus.wb_d, 32'd0);
        chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);

        // ALU only
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        #1 chk("alu_ready", 32'(bus.alu_ready), 32'd1);
        tick();
        bus.alu_valid = 1'b0;
        chk("alu_wb_we", 32'(bus.wb_we), 32'd1);
        chk("alu_wb_rd", 32'(bus.wb_rd), 32'd5);
        chk("alu_wb_d", bus.wb_d, 32'hDEADBEEF);
        tick();
        chk("alu_idle_we", 32'(bus.wb_we), 32'd0);

        // Scoreboard set then clear by LSU pop
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        tick();
        bus.iss_valid = 1'b0; bus.rs1 = 5'd7;
        #1 chk("sb_busy_set", 32'(bus.rs1_busy), 32'd1);
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h12;
        #1 chk("sb_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        tick();
        bus.lsu_valid = 1'b0;
        chk("sb_busy_before_pop", 32'(bus.rs1_busy), 32'd1);
        chk("sb_no_bypass_we", 32'(bus.wb_we), 32'd0);
        tick();
        chk("sb_busy_cleared", 32'(bus.rs1_busy), 32'd0);
        chk("sb_wb_we", 32'(bus.wb_we), 32'd1);
        chk("sb_wb_rd", 32'(bus.wb_rd), 32'd7);
        chk("sb_wb_d", bus.wb_d, 32'h12);
        tick();
        chk("sb_idle_we", 32'(bus.wb_we), 32'd0);

        // Starvation: ALU every cycle, two LSU pushes
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'd1;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_data = 32'hA0A0;
        tick();
        bus.alu_data = 32'd2; bus.lsu_rd = 5'd11; bus.lsu_data = 32'hB0B0;
        chk("st_alu_wb_d", bus.wb_d, 32'd1);
        chk("st_lsu_ready_1", 32'(bus.lsu_ready), 32'd1);
        tick();
        bus.lsu_valid = 1'b0; bus.alu_data = 32'd3;
        chk("st_full", 32'(bus.lsu_ready), 32'd0);
        chk("st_alu_win2", bus.wb_d, 32'd2);
        tick();
        bus.alu_data = 32'd4;
        tick();
        bus.alu_data = 32'd5;
        chk("st_alu_ready_3", 32'(bus.alu_ready), 32'd1);
        tick();
        chk("st_alu_win4", bus.wb_d, 32'd5);
        chk("st_force_ready", 32'(bus.alu_ready), 32'd0);
        tick();
        chk("st_force_we", 32'(bus.wb_we), 32'd1);
        chk("st_force_rd", 32'(bus.wb_rd), 32'd10);
        chk("st_force_d", bus.wb_d, 32'hA0A0);
        chk("st_ready_back", 32'(bus.alu_ready), 32'd1);
        chk("st_not_full", 32'(bus.lsu_ready), 32'd1);
        bus.alu_valid = 1'b0;
        tick();
        chk("st_drain_rd", 32'(bus.wb_rd), 32'd11);
        chk("st_drain_d", bus.wb_d, 32'hB0B0);
        tick();
        chk("st_idle_we", 32'(bus.wb_we), 32'd0);

        // x0 writes are consumed but never enabled
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFFFFFF;
        #1 chk("x0_alu_ready", 32'(bus.alu_ready), 32'd1);
        tick();
        bus.alu_valid = 1'b0;
        chk("x0_alu_we", 32'(bus.wb_we), 32'd0);
        chk("x0_alu_d", bus.wb_d, 32'hFFFFFFFF);
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h55;
        tick();
        bus.lsu_valid = 1'b0;
        tick();
        chk("x0_lsu_we", 32'(bus.wb_we), 32'd0);
        chk("x0_lsu_d", bus.wb_d, 32'h55);

        // Same-cycle issue set and pop clear on rd=9
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        tick();
        bus.iss_valid = 1'b0;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
        tick();
        bus.lsu_valid = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        tick();
        bus.iss_valid = 1'b0; bus.rs2 = 5'd9;
        #1 chk("col_busy_kept", 32'(bus.rs2_busy), 32'd1);
        chk("col_wb_rd", 32'(bus.wb_rd), 32'd9);
        chk("col_wb_d", bus.wb_d, 32'h99);

        // Mid-stream reset with two queued loads
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd12;
        tick();
        bus.iss_valid = 1'b0; bus.rs1 = 5'd12;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd13; bus.lsu_data = 32'h13;
        tick();
        bus.lsu_rd = 5'd14; bus.lsu_data = 32'h14;
        tick();
        bus.lsu_valid = 1'b0;
        chk("rs_pre_full", 32'(bus.lsu_ready), 32'd0);
        chk("rs_pre_busy", 32'(bus.rs1_busy), 32'd1);
        chk("rs_pre_we", 32'(bus.wb_we), 32'd1);
        #2 rst_n = 1'b0;
        bus.alu_valid = 1'b0;
        #1;
        chk("rs_async_we", 32'(bus.wb_we), 32'd0);
        chk("rs_async_ready", 32'(bus.lsu_ready), 32'd1);
        chk("rs_async_busy", 32'(bus.rs1_busy), 32'd0);
        chk("rs_async_busy9", 32'(bus.rs2_busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rs_post_we1", 32'(bus.wb_we), 32'd0);
        tick();
        chk("rs_post_we2", 32'(bus.wb_we), 32'd0);
        chk("rs_post_ready", 32'(bus.lsu_ready), 32'd1);
        tick();
        chk("rs_post_we3", 32'(bus.wb_we), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
